// File: rtl/nsl_sample_loader_if.sv
`default_nettype none
// ============================================================================
// nsl_sample_loader_if : feature-word stream in, parallel PCA sample frame out
// Rev 1.0
// ============================================================================
interface nsl_sample_loader_if #(
  parameter int PC_NUM  = 32,
  parameter int FP_SIZE = 64,
  parameter int CNT_W   = 16
);
  logic [FP_SIZE-1:0] in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [FP_SIZE-1:0] input_samples [0:PC_NUM-1];
  logic               out_valid;
  logic               out_ready;
  logic               err_short;
  logic               err_long;
  logic [CNT_W-1:0]   frame_cnt;

  // Upstream feeder / downstream consumer side
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, input_samples, out_valid, err_short, err_long, frame_cnt
  );

  // Loader side
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, input_samples, out_valid, err_short, err_long, frame_cnt
  );
endinterface

`default_nettype wire

// File: rtl/nsl_sample_loader.sv
`default_nettype none
// ============================================================================
// nsl_sample_loader : ping-pong frame assembler feeding the PCA scoring stage
// Rev 1.0
// ============================================================================
module nsl_sample_loader #(
  parameter int PC_NUM  = 32,
  parameter int FP_SIZE = 64,
  parameter int CNT_W   = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  nsl_sample_loader_if.slave bus
);
  localparam int              IDX_W    = (PC_NUM > 1) ? $clog2(PC_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PC_NUM - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    DROP = 1'b1
  } state_t;

  state_t             state_q;
  logic [FP_SIZE-1:0] bank_q [2][PC_NUM];
  logic [1:0]         full_q;
  logic               wr_sel_q;
  logic               rd_sel_q;
  logic [IDX_W-1:0]   idx_q;
  logic               err_short_q;
  logic               err_long_q;
  logic [CNT_W-1:0]   frame_cnt_q;

  logic in_ready;
  logic accept;
  logic take;

  // in_ready depends only on registered state, never on out_ready
  assign in_ready = (state_q == DROP) || !full_q[wr_sel_q];
  assign accept   = bus.in_valid && in_ready;
  assign take     = full_q[rd_sel_q] && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      full_q      <= 2'b00;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      idx_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frame_cnt_q <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < PC_NUM; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;

      // Release and completion always touch different banks, so both may apply
      if (take) begin
        full_q[rd_sel_q] <= 1'b0;
        rd_sel_q         <= ~rd_sel_q;
      end

      if (accept) begin
        case (state_q)
          FILL: begin
            bank_q[wr_sel_q][idx_q] <= bus.in_data;
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              if (bus.in_last) begin
                full_q[wr_sel_q] <= 1'b1;
                wr_sel_q         <= ~wr_sel_q;
                frame_cnt_q      <= frame_cnt_q + CNT_W'(1);
              end else begin
                err_long_q <= 1'b1;
                state_q    <= DROP;
              end
            end else if (bus.in_last) begin
              err_short_q <= 1'b1;
              idx_q       <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
          DROP: begin
            if (bus.in_last) begin
              state_q <= FILL;
              idx_q   <= '0;
            end
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = full_q[rd_sel_q];
  assign bus.err_short = err_short_q;
  assign bus.err_long  = err_long_q;
  assign bus.frame_cnt = frame_cnt_q;

  for (genvar g = 0; g < PC_NUM; g++) begin : g_out
    assign bus.input_samples[g] = bank_q[rd_sel_q][g];
  end
endmodule

`default_nettype wire

// File: tb/tb_nsl_sample_loader.sv
`default_nettype none
// ============================================================================
// tb_nsl_sample_loader : scoreboard bench for the ping-pong sample loader
// Rev 1.0
// ============================================================================
module tb_nsl_sample_loader;
  localparam int PC    = 32;
  localparam int FPW   = 64;
  localparam int CW    = 16;

  typedef logic [FPW-1:0] frame_t [PC];

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  frame_t sb [$];

  nsl_sample_loader_if #(.PC_NUM(PC), .FP_SIZE(FPW), .CNT_W(CW)) bus ();

  nsl_sample_loader #(.PC_NUM(PC), .FP_SIZE(FPW), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fv(input int base, input int k);
    return $realtobits(real'(base + k + 1));
  endfunction

  task automatic push_frame(input int base);
    frame_t f;
    for (int k = 0; k < PC; k++) f[k] = fv(base, k);
    sb.push_back(f);
  endtask

  // Holds the beat until accepted; returns #1 after the accepting edge
  task automatic send_beat(input logic [63:0] d, input logic l);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check_val("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input int base, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      if (k == nbeats - 1 && nbeats == PC) push_frame(base);
      send_beat(fv(base, k), k == nbeats - 1);
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_val("drain", 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: every taken frame is popped and compared; held frames must stay stable
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid) begin
        if (sb.size() == 0) begin
          check_val("unexpected_frame", 64'd1, 64'd0);
        end else if (bus.out_ready) begin
          for (int k = 0; k < PC; k++)
            check_val($sformatf("data[%0d]", k), bus.input_samples[k], sb[0][k]);
          void'(sb.pop_front());
        end else begin
          check_val("hold[0]", bus.input_samples[0], sb[0][0]);
          check_val("hold[31]", bus.input_samples[PC-1], sb[0][PC-1]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    check_val("rst_err_short", 64'(bus.err_short), 64'd0);
    check_val("rst_err_long", 64'(bus.err_long), 64'd0);
    check_val("rst_sample0", bus.input_samples[0], 64'd0);

    // Single frame 1.0..32.0, consumer ready
    bus.out_ready = 1'b1;
    for (int k = 0; k < PC - 1; k++) send_beat(fv(0, k), 1'b0);
    check_val("t1_ov_before", 64'(bus.out_valid), 64'd0);
    push_frame(0);
    send_beat(fv(0, PC - 1), 1'b1);
    check_val("t1_ov_after", 64'(bus.out_valid), 64'd1);
    check_val("t1_s0", bus.input_samples[0], $realtobits(1.0));
    check_val("t1_s31", bus.input_samples[PC-1], $realtobits(32.0));
    check_val("t1_cnt", 64'(bus.frame_cnt), 64'd1);
    wait_drain();
    check_val("t1_ov_gone", 64'(bus.out_valid), 64'd0);

    // Backpressure: both banks fill, third frame stalls
    bus.out_ready = 1'b0;
    send_frame(10, PC);
    send_frame(50, PC);
    check_val("t2_in_ready_full", 64'(bus.in_ready), 64'd0);
    check_val("t2_cnt", 64'(bus.frame_cnt), 64'd3);
    bus.in_valid = 1'b1;
    bus.in_data  = fv(90, 0);
    bus.in_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("t2_stall", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_val("t2_in_ready_back", 64'(bus.in_ready), 64'd1);
    check_val("t2_next_visible", 64'(bus.out_valid), 64'd1);
    for (int k = 0; k < PC; k++) begin
      if (k == PC - 1) push_frame(90);
      send_beat(fv(90, k), k == PC - 1);
    end
    check_val("t2_cnt2", 64'(bus.frame_cnt), 64'd4);
    check_val("t2_full_again", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    wait_drain();

    // Short frame then a good frame
    send_frame(400, 5);
    check_val("t3_err_short", 64'(bus.err_short), 64'd1);
    check_val("t3_no_ov", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check_val("t3_err_short_end", 64'(bus.err_short), 64'd0);
    send_frame(500, PC);
    check_val("t3_cnt", 64'(bus.frame_cnt), 64'd5);
    wait_drain();

    // Long frame: 40 beats, last on beat 40
    for (int k = 0; k < 40; k++) begin
      send_beat(fv(600, k), k == 39);
      if (k == PC - 1) check_val("t4_err_long", 64'(bus.err_long), 64'd1);
      if (k == PC) check_val("t4_err_long_end", 64'(bus.err_long), 64'd0);
    end
    check_val("t4_no_ov", 64'(bus.out_valid), 64'd0);
    check_val("t4_no_short", 64'(bus.err_short), 64'd0);
    check_val("t4_cnt", 64'(bus.frame_cnt), 64'd5);
    send_frame(700, PC);
    check_val("t4_cnt2", 64'(bus.frame_cnt), 64'd6);
    wait_drain();

    // Take of read bank coincides with completion of the write bank
    bus.out_ready = 1'b0;
    send_frame(800, PC);
    for (int k = 0; k < PC - 1; k++) send_beat(fv(900, k), 1'b0);
    check_val("t5_ov_pre", 64'(bus.out_valid), 64'd1);
    push_frame(900);
    bus.out_ready = 1'b1;
    send_beat(fv(900, PC - 1), 1'b1);
    check_val("t5_ov_post", 64'(bus.out_valid), 64'd1);
    check_val("t5_new_s0", bus.input_samples[0], fv(900, 0));
    check_val("t5_cnt", 64'(bus.frame_cnt), 64'd8);
    wait_drain();

    // Reset on beat 17 with one frame held
    bus.out_ready = 1'b0;
    send_frame(1000, PC);
    for (int k = 0; k < 16; k++) send_beat(fv(1100, k), 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = fv(1100, 16);
    bus.in_last  = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    check_val("t6_ov", 64'(bus.out_valid), 64'd0);
    check_val("t6_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("t6_cnt", 64'(bus.frame_cnt), 64'd0);
    check_val("t6_err_short", 64'(bus.err_short), 64'd0);
    check_val("t6_err_long", 64'(bus.err_long), 64'd0);
    for (int k = 0; k < PC; k++)
      check_val($sformatf("t6_zero[%0d]", k), bus.input_samples[k], 64'd0);

    // Clean frame after reset starts at element 0
    bus.out_ready = 1'b1;
    send_frame(1200, PC);
    check_val("t7_cnt", 64'(bus.frame_cnt), 64'd1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/nsl_sample_loader.md
Name: nsl_sample_loader

Overview:
- Upstream feeder for the PCA intrusion-detection datapath.
- Accepts a serial stream of FP_SIZE-bit feature words, one feature per beat, and assembles each frame of PC_NUM features into a parallel sample vector.
- The vector drives the input_samples array of the PCA scoring stage.
- Uses ping-pong double buffering so one frame can fill while the previous one is held for the consumer.

Parameters:
- PC_NUM, 32: features per frame; the sample vector has this many elements.
- FP_SIZE, 64: width of each feature word (IEEE-754 double, passed through untouched).
- CNT_W, 16: width of the accepted-frame counter.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  FP_SIZE  feature word.
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  marks the final feature of a frame; qualified by in_valid.
- in_ready  output  1  loader accepts a beat this cycle.
- input_samples  output  FP_SIZE x [0:PC_NUM-1]  assembled frame; element 0 is the first beat.
- out_valid  output  1  input_samples holds a complete frame.
- out_ready  input  1  consumer takes the frame this cycle.
- err_short  output  1  one-cycle pulse: in_last arrived before beat PC_NUM-1.
- err_long  output  1  one-cycle pulse: beat PC_NUM-1 arrived without in_last.
- frame_cnt  output  CNT_W  count of good frames delivered to a bank; wraps modulo 2^CNT_W.

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (reset). reset has priority over all other activity.
- Reset values:
  - both banks marked empty and both bank contents cleared to 0;
  - wr_sel=0, rd_sel=0, idx=0, state FILL;
  - out_valid=0, input_samples all 0, err_short=0, err_long=0, frame_cnt=0.
- Storage: two banks of PC_NUM x FP_SIZE, each with a full flag. The write bank is wr_sel; the read bank is rd_sel.
- States:
  - FILL: in_ready = !full[wr_sel].
  - DROP: in_ready = 1 (all beats are discarded).
- A beat is accepted when in_valid && in_ready.
- FILL, accepted beat: bank[wr_sel][idx] <= in_data, then:
  - idx < PC_NUM-1 and !in_last: idx++.
  - idx < PC_NUM-1 and in_last: err_short pulses next cycle; idx<=0; bank not marked full (partial frame discarded); stay in FILL.
  - idx == PC_NUM-1 and in_last: full[wr_sel]<=1; wr_sel toggles; idx<=0; frame_cnt++.
  - idx == PC_NUM-1 and !in_last: err_long pulses next cycle; idx<=0; bank not marked full; go to DROP.
- DROP: beats are accepted and discarded. The first accepted beat with in_last returns the block to FILL with idx=0. No error pulse is generated in DROP.
- Output side:
  - out_valid = full[rd_sel] (registered flag).
  - input_samples = bank[rd_sel] (registered storage, mux on rd_sel).
  - On out_valid && out_ready: full[rd_sel]<=0 and rd_sel toggles.
  - While out_valid=1, input_samples is stable until the frame is taken.
- Latency: a final beat accepted at cycle N gives out_valid=1 at N+1 if the read bank was empty.
- Throughput: one beat per cycle sustained when out_ready is held high.
- Simultaneous events:
  - Release of the read bank and completion of the write bank in the same cycle are legal, since they are always different banks. Both flag updates apply.
  - A bank freed at cycle N raises in_ready at N+1; there is no combinational path from out_ready to in_ready.
- Both banks full: in_ready=0 and the upstream stalls. idx and partial data are preserved.
- Reset mid-frame: the partial frame and any held frames are lost. No error pulse is produced.
- The counter wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then send one frame of 32 beats with values 1.0..32.0 (in_last on beat 32), out_ready=1 -> out_valid high exactly one cycle after beat 32; input_samples[0]=1.0 and [31]=32.0; frame_cnt=1.
- Backpressure: out_ready=0 and three back-to-back frames -> in_ready falls after beat 64. Raise out_ready for one cycle -> frame 1 delivered, in_ready returns next cycle, frame 2 then becomes visible with unchanged data.
- Short frame: in_last on beat 5 -> err_short pulses one cycle, no out_valid. A following good frame is delivered with element 0 equal to its own first beat; frame_cnt increments by 1 only.
- Long frame: 40 beats with in_last on beat 40 -> err_long pulses one cycle after beat 32, beats 33-40 are swallowed, no out_valid. The next frame is delivered correctly.
- Simultaneous: the read bank is taken in the same cycle the other bank's final beat is accepted -> out_valid stays high continuously and the new frame appears the next cycle.
- Reset asserted on beat 17 with one frame held -> next cycle out_valid=0, in_ready=1, frame_cnt=0, all input_samples 0.
